// File: rtl/mult_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mult_share_ctrl
//  Brief    : Round-robin share of one sequential signed multiplier between
//             two requesters, with cycle-counted run timing.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_share_ctrl #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 34,
    parameter int CNT_W       = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_m,
    input  logic [DATA_W-1:0]     req0_q,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_m,
    input  logic [DATA_W-1:0]     req1_q,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  busy,
    output logic                  mult_reset,
    output logic                  mult_en,
    output logic [DATA_W-1:0]     mult_m,
    output logic [DATA_W-1:0]     mult_q,
    output logic                  mult_plus,
    input  logic [2*DATA_W-1:0]   mult_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_m;
    logic [DATA_W-1:0]   r_q;
    logic [2*DATA_W-1:0] r_rsp;
    logic                r_owner;
    logic                r_last_grant;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic                w_rsp_taken;

    // On a tie the requester that did not win last time gets the grant.
    assign w_gnt0      = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1      = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept    = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);
    assign w_rsp_taken = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_m          <= '0;
            r_q          <= '0;
            r_rsp        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m          <= w_gnt1 ? req1_m : req0_m;
                        r_q          <= w_gnt1 ? req1_q : req0_q;
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                    end
                end
                S_LOAD:  r_cnt <= '0;
                S_RUN:   r_cnt <= r_cnt + c_cnt_one;
                S_DRAIN: r_rsp <= mult_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        mult_reset = 1'b1;
        mult_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                mult_reset = 1'b0;
                mult_en    = 1'b1;
                if (r_cnt == c_cnt_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold the multiplier frozen for one cycle so out is sampled stable.
                mult_reset = 1'b0;
                w_next     = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = ~r_owner;
                rsp1_valid = r_owner;
                if (w_rsp_taken) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign mult_m    = r_m;
    assign mult_q    = r_q;
    assign mult_plus = 1'b1;
    assign rsp_data  = r_rsp;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_ctrl
//  Brief    : Scoreboard bench for mult_share_ctrl with a timed multiplier model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_ctrl;

    localparam int DW = 32;
    localparam int MC = 34;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [63:0]   rsp_data;
    logic          busy, mult_reset, mult_en, mult_plus;
    logic [DW-1:0] mult_m, mult_q;
    logic [63:0]   mult_out;

    mult_share_ctrl #(.DATA_W(DW), .MULT_CYCLES(MC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_q(req0_q),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_q(req1_q),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy),
        .mult_reset(mult_reset), .mult_en(mult_en),
        .mult_m(mult_m), .mult_q(mult_q), .mult_plus(mult_plus), .mult_out(mult_out)
    );

    always #5 clk = ~clk;

    // Multiplier model: out is correct only after exactly MC enabled cycles.
    logic [5:0]  m_cnt = '0;
    logic [63:0] w_prod;
    assign w_prod   = $signed({{32{mult_m[31]}}, mult_m}) * $signed({{32{mult_q[31]}}, mult_q});
    assign mult_out = (m_cnt == 6'(MC)) ? w_prod : (w_prod ^ 64'hA5A5_5A5A_0F0F_F0F0);
    always @(posedge clk) begin
        if (mult_reset) m_cnt <= '0;
        else if (mult_en && m_cnt != 6'd63) m_cnt <= m_cnt + 6'd1;
    end

    int en_cnt = 0;
    always @(posedge clk) if (mult_en) en_cnt <= en_cnt + 1;

    typedef struct packed {
        logic        owner;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_fail = 0, n_rsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 64'd1, 64'd0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_data, 64'hXXXX_XXXX_XXXX_XXXX);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_owner", {63'd0, rsp1_valid}, {63'd0, e.owner});
                    chk("rsp_data", rsp_data, e.data);
                    n_rsp++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic r, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp, input bit push);
        int k;
        exp_t e;
        if (push) begin
            e.owner = r;
            e.data  = exp;
            sb.push_back(e);
        end
        if (r) begin req1_m = m; req1_q = q; req1_valid = 1'b1; end
        else   begin req0_m = m; req0_q = q; req0_valid = 1'b1; end
        k = 0;
        @(negedge clk);
        while (!(r ? req1_ready : req0_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("accept_timeout", 64'd0, 64'd1);
        tick();
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat, e0, base, k;
        exp_t e;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mult_reset", {63'd0, mult_reset}, 64'd1);
        chk("rst_mult_en", {63'd0, mult_en}, 64'd0);
        chk("rst_mult_mq", {mult_m, mult_q}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        chk("mult_plus", {63'd0, mult_plus}, 64'd1);
        reset = 1'b1;
        tick();

        // Single request with latency and enable-length checks
        e0 = en_cnt;
        issue(1'b0, 32'd7, 32'd2, 64'd14, 1'b1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_ops", {mult_m, mult_q}, {32'd7, 32'd2});
        lat = 0;
        while (!rsp0_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'(MC + 2));
        chk("t1_rsp1_quiet", {63'd0, rsp1_valid}, 64'd0);
        wait_idle();
        chk("t1_en_cycles", 64'(en_cnt - e0), 64'(MC));

        // Simultaneous requests right after reset: requester 0 first
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        e.owner = 1'b0; e.data = 64'd10; sb.push_back(e);
        e.owner = 1'b1; e.data = 64'd9;  sb.push_back(e);
        req0_m = 32'hFFFF_FFFE; req0_q = 32'hFFFF_FFFB; req0_valid = 1'b1;
        req1_m = 32'd3;         req1_q = 32'd3;         req1_valid = 1'b1;
        @(negedge clk);
        chk("t2_ready", {62'd0, req1_ready, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        base = n_rsp;
        k = 0;
        @(negedge clk);
        while (!req1_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t2_req1_after_rsp0", 64'(n_rsp), 64'(base + 1));
        tick();
        req1_valid = 1'b0;
        wait_idle();

        // Fairness under continuous contention
        for (int j = 0; j < 4; j++) begin
            e.owner = j[0];
            e.data  = j[0] ? 64'hFFFF_FFFF_FFFF_FFF6 : 64'd6;
            sb.push_back(e);
        end
        req0_m = 32'hFFFF_FFFE; req0_q = 32'hFFFF_FFFD; req0_valid = 1'b1;
        req1_m = 32'd2;         req1_q = 32'hFFFF_FFFB; req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            k = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("t3_grant", {62'd0, req1_ready, req0_ready}, j[0] ? 64'd2 : 64'd1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Backpressure on requester 1's response
        rsp1_ready = 1'b0;
        issue(1'b1, 32'hFFFF_FFFB, 32'd2, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1);
        k = 0;
        while (!rsp1_valid && k < 100) begin
            tick();
            k++;
        end
        req0_m = 32'd3; req0_q = 32'd3; req0_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t4_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
            chk("t4_rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFF6);
            chk("t4_busy", {63'd0, busy}, 64'd1);
            chk("t4_mult_en", {63'd0, mult_en}, 64'd0);
            chk("t4_req0_ready", {63'd0, req0_ready}, 64'd0);
        end
        req0_valid = 1'b0;
        tick();
        rsp1_ready = 1'b1;
        wait_idle();

        // Reset during RUN drops the job
        issue(1'b0, 32'd9, 32'd9, 64'd81, 1'b0);
        tick();
        repeat (5) tick();
        chk("t5_mult_en_run", {63'd0, mult_en}, 64'd1);
        reset = 1'b0;
        tick();
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_mult_en", {63'd0, mult_en}, 64'd0);
        chk("t5_mult_reset", {63'd0, mult_reset}, 64'd1);
        chk("t5_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        reset = 1'b1;
        repeat (45) tick();
        chk("t5_still_idle", {63'd0, busy}, 64'd0);
        issue(1'b0, 32'd2, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1);
        wait_idle();

        // Edge operands
        issue(1'b0, 32'hF000_00F5, 32'd0, 64'd0, 1'b1);
        wait_idle();
        issue(1'b0, 32'd1, 32'd15, 64'd15, 1'b1);
        wait_idle();
        issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
